vx_mem_unit: RTL and testbench

Memory-stage sequencer on the consuming side of the execute/memory pipeline register. It takes the per-thread load/store operation held in that register, serializes it into one-thread-at-a-time requests on a single-ported data-cache interface, and gathers and aligns load data. While the operation is in flight it drives `out_freeze` back to the register so the register's outputs stay stable. When all threads are done it presents the results to the memory/writeback register for exactly one cycle.

---
 rtl/vx_mem_unit_if.sv | 41 ++++
 rtl/vx_mem_unit.sv | 81 ++++++++
 tb/tb_vx_mem_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/vx_mem_unit_if.sv
// vx_mem_unit_if: pipeline-register and data-cache signals of the memory-stage sequencer
interface vx_mem_unit_if #(parameter int NT = 4, parameter int NW = 8);
  localparam int WW = $clog2(NW);
  logic [2:0] in_mem_read;
  logic [2:0] in_mem_write;
  logic [NT*32-1:0] in_alu_result;
  logic [NT*32-1:0] in_b_reg_data;
  logic [NT-1:0] in_valid;
  logic [4:0] in_rd;
  logic [1:0] in_wb;
  logic [WW-1:0] in_warp_num;
  logic out_freeze;
  logic out_cache_req_valid;
  logic [31:0] out_cache_req_addr;
  logic out_cache_req_we;
  logic [3:0] out_cache_req_be;
  logic [31:0] out_cache_req_wdata;
  logic in_cache_req_ready;
  logic in_cache_rsp_valid;
  logic [31:0] in_cache_rsp_data;
  logic [NT*32-1:0] out_mem_result;
  logic out_mem_valid;
  logic [NT-1:0] out_valid;
  logic [4:0] out_rd;
  logic [1:0] out_wb;
  logic [WW-1:0] out_warp_num;
  modport slave (
    input in_mem_read, in_mem_write, in_alu_result, in_b_reg_data, in_valid, in_rd, in_wb,
          in_warp_num, in_cache_req_ready, in_cache_rsp_valid, in_cache_rsp_data,
    output out_freeze, out_cache_req_valid, out_cache_req_addr, out_cache_req_we,
           out_cache_req_be, out_cache_req_wdata, out_mem_result, out_mem_valid, out_valid,
           out_rd, out_wb, out_warp_num
  );
  modport master (
    output in_mem_read, in_mem_write, in_alu_result, in_b_reg_data, in_valid, in_rd, in_wb,
           in_warp_num, in_cache_req_ready, in_cache_rsp_valid, in_cache_rsp_data,
    input out_freeze, out_cache_req_valid, out_cache_req_addr, out_cache_req_we,
          out_cache_req_be, out_cache_req_wdata, out_mem_result, out_mem_valid, out_valid,
          out_rd, out_wb, out_warp_num
  );
endinterface

// File: rtl/vx_mem_unit.sv
// vx_mem_unit: serializes per-thread loads/stores onto a single-ported data cache and gathers aligned load data
module vx_mem_unit #(
  parameter int NT = 4,
  parameter int NW = 8
) (
  input logic clk,
  input logic reset_n,
  vx_mem_unit_if.slave bus
);
  localparam int TW = NT > 1 ? $clog2(NT) : 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state;
  logic [NT-1:0] mask, mask_next;
  logic [TW-1:0] tid;
  logic pending, is_load;
  logic [31:0] addr, sdata, rdata, ld_data;
  logic [1:0] off;
  logic [7:0] lb;
  logic [15:0] lh;
  assign pending = bus.in_mem_read != 3'd7 || bus.in_mem_write != 3'd7;
  assign is_load = bus.in_mem_read != 3'd7;
  // clearing the lowest set bit retires the thread currently being served
  assign mask_next = mask & (mask - NT'(1));
  always_comb begin
    tid = '0;
    for (int i = NT - 1; i >= 0; i--) if (mask[i]) tid = TW'(i);
  end
  assign addr = bus.in_alu_result[32*tid +: 32];
  assign sdata = bus.in_b_reg_data[32*tid +: 32];
  assign off = addr[1:0];
  assign rdata = bus.in_cache_rsp_data;
  assign lb = rdata[8*off +: 8];
  assign lh = off[1] ? rdata[31:16] : rdata[15:0];
  assign ld_data = bus.in_mem_read == 3'd0 ? {{24{lb[7]}}, lb} :
                   bus.in_mem_read == 3'd1 ? {{16{lh[15]}}, lh} :
                   bus.in_mem_read == 3'd4 ? {24'b0, lb} :
                   bus.in_mem_read == 3'd5 ? {16'b0, lh} : rdata;
  assign bus.out_freeze = reset_n && pending && state != DONE;
  assign bus.out_cache_req_valid = state == REQ;
  assign bus.out_cache_req_addr = {addr[31:2], 2'b00};
  assign bus.out_cache_req_we = !is_load;
  assign bus.out_cache_req_be = is_load ? 4'hF :
                                bus.in_mem_write == 3'd0 ? 4'b0001 << off :
                                bus.in_mem_write == 3'd1 ? (off[1] ? 4'b1100 : 4'b0011) : 4'hF;
  assign bus.out_cache_req_wdata = bus.in_mem_write == 3'd0 ? {4{sdata[7:0]}} :
                                   bus.in_mem_write == 3'd1 ? {2{sdata[15:0]}} : sdata;
  assign bus.out_mem_valid = state == DONE;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      mask <= '0;
      bus.out_valid <= '0;
      bus.out_rd <= '0;
      bus.out_wb <= '0;
      bus.out_warp_num <= '0;
      bus.out_mem_result <= '0;
    end else begin
      case (state)
        IDLE: if (pending) begin
          mask <= bus.in_valid;
          bus.out_valid <= bus.in_valid;
          bus.out_rd <= bus.in_rd;
          bus.out_wb <= bus.in_wb;
          bus.out_warp_num <= bus.in_warp_num;
          bus.out_mem_result <= '0;
          state <= |bus.in_valid ? REQ : DONE;
        end
        REQ: if (bus.in_cache_req_ready) begin
          if (!is_load) mask <= mask_next;
          state <= is_load ? WAIT : (|mask_next ? REQ : DONE);
        end
        WAIT: if (bus.in_cache_rsp_valid) begin
          bus.out_mem_result[32*tid +: 32] <= ld_data;
          mask <= mask_next;
          state <= |mask_next ? REQ : DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vx_mem_unit.sv
// tb_vx_mem_unit: vector table plus hand sequences; expected cache requests are queued at issue and checked as they appear
module tb_vx_mem_unit;
  localparam int NT = 4, NW = 8;
  logic clk = 0, reset_n = 0;
  always #5 clk = ~clk;
  vx_mem_unit_if #(.NT(NT), .NW(NW)) bus();
  vx_mem_unit #(.NT(NT), .NW(NW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  typedef struct {
    logic [31:0] addr;
    logic we;
    logic [3:0] be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } req_t;
  typedef struct {
    logic [2:0] rd, wr;
    logic [3:0] valid;
    logic [31:0] addr, data, rsp, res, wd;
    logic [3:0] be;
  } vec_t;
  req_t q[$];
  int tests = 0, fails = 0, opn = 0;
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic nop();
    bus.in_mem_read = 3'd7;
    bus.in_mem_write = 3'd7;
  endtask
  task automatic run_op(input string nm, input logic [2:0] rd, input logic [2:0] wr,
                        input logic [3:0] valid, input logic [3:0][31:0] a, input logic [3:0][31:0] d,
                        input logic [3:0][31:0] r, input logic [3:0][31:0] x,
                        input logic [3:0][3:0] be, input logic [3:0][31:0] wd, input int stall);
    req_t e;
    int frz = 0, st = stall;
    bit ld = rd != 3'd7;
    bit pend = 0, done = 0;
    logic [31:0] pdata = 0;
    int exp_frz = 1 + $countones(valid) * (ld ? 2 : 1) + stall;
    opn++;
    bus.in_mem_read = rd;
    bus.in_mem_write = wr;
    bus.in_alu_result = a;
    bus.in_b_reg_data = d;
    bus.in_valid = valid;
    bus.in_rd = 5'(opn);
    bus.in_wb = 2'(opn);
    bus.in_warp_num = 3'(opn * 3);
    for (int t = 0; t < 4; t++) if (valid[t]) q.push_back('{a[t] & 32'hFFFF_FFFC, !ld, be[t], wd[t], r[t]});
    for (int c = 0; c < 80 && !done; c++) begin
      #1;
      if (bus.out_freeze) frz++;
      bus.in_cache_req_ready = 0;
      bus.in_cache_rsp_valid = pend;
      bus.in_cache_rsp_data = pend ? pdata : 32'h0;
      pend = 0;
      if (bus.out_mem_valid) begin
        done = 1;
        nop();
        check({nm, " out_valid"}, bus.out_valid, valid);
        check({nm, " result"}, bus.out_mem_result, x);
        check({nm, " rd/wb/warp"}, {bus.out_rd, bus.out_wb, bus.out_warp_num},
              {5'(opn), 2'(opn), 3'(opn * 3)});
        check({nm, " freeze cycles"}, frz, exp_frz);
      end else if (bus.out_cache_req_valid) begin
        if (q.size() == 0) check({nm, " unexpected req"}, bus.out_cache_req_valid, 0);
        else begin
          e = q[0];
          check({nm, " req addr"}, bus.out_cache_req_addr, e.addr);
          check({nm, " req we"}, bus.out_cache_req_we, e.we);
          if (!ld) begin
            check({nm, " req be"}, bus.out_cache_req_be, e.be);
            check({nm, " req wdata"}, bus.out_cache_req_wdata, e.wdata);
          end
          if (st > 0) st--;
          else begin
            bus.in_cache_req_ready = 1;
            void'(q.pop_front());
            pend = ld;
            pdata = e.rdata;
          end
        end
      end
      if (!done) @(negedge clk);
    end
    check({nm, " completed"}, done, 1);
    check({nm, " all reqs issued once"}, q.size(), 0);
    nop();
    q.delete();
    @(negedge clk);
    #1;
    check({nm, " single pulse"}, bus.out_mem_valid, 0);
    check({nm, " freeze low after"}, bus.out_freeze, 0);
  endtask
  vec_t v[13];
  logic [3:0][31:0] x;
  initial begin
    v[0]  = '{3'd0, 3'd7, 4'b0001, 32'h203, 32'h0, 32'h80FF_FF12, 32'hFFFF_FF80, 32'h0, 4'h0};
    v[1]  = '{3'd4, 3'd7, 4'b0100, 32'h203, 32'h0, 32'h80FF_FF12, 32'h0000_0080, 32'h0, 4'h0};
    v[2]  = '{3'd1, 3'd7, 4'b0010, 32'h202, 32'h0, 32'h8001_1234, 32'hFFFF_8001, 32'h0, 4'h0};
    v[3]  = '{3'd5, 3'd7, 4'b1000, 32'h203, 32'h0, 32'h8001_1234, 32'h0000_8001, 32'h0, 4'h0};
    v[4]  = '{3'd2, 3'd7, 4'b0001, 32'h204, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 4'h0};
    v[5]  = '{3'd0, 3'd7, 4'b0001, 32'h200, 32'h0, 32'h0000_007F, 32'h0000_007F, 32'h0, 4'h0};
    v[6]  = '{3'd1, 3'd7, 4'b0100, 32'h200, 32'h0, 32'h0000_F00D, 32'hFFFF_F00D, 32'h0, 4'h0};
    v[7]  = '{3'd4, 3'd7, 4'b0001, 32'h202, 32'h0, 32'h80FF_FF12, 32'h0000_00FF, 32'h0, 4'h0};
    v[8]  = '{3'd2, 3'd2, 4'b0010, 32'h208, 32'h5555_5555, 32'h1357_9BDF, 32'h1357_9BDF, 32'h0, 4'h0};
    v[9]  = '{3'd7, 3'd1, 4'b0001, 32'h202, 32'h0000_ABCD, 32'h0, 32'h0, 32'hABCD_ABCD, 4'b1100};
    v[10] = '{3'd7, 3'd0, 4'b0100, 32'h201, 32'h1234_5678, 32'h0, 32'h0, 32'h7878_7878, 4'b0010};
    v[11] = '{3'd7, 3'd2, 4'b1000, 32'h300, 32'hCAFE_F00D, 32'h0, 32'h0, 32'hCAFE_F00D, 4'b1111};
    v[12] = '{3'd7, 3'd1, 4'b0001, 32'h100, 32'h0000_1234, 32'h0, 32'h0, 32'h1234_1234, 4'b0011};
    bus.in_mem_read = 3'd2;
    bus.in_mem_write = 3'd7;
    bus.in_valid = 4'hF;
    bus.in_alu_result = '0;
    bus.in_b_reg_data = '0;
    bus.in_rd = 0;
    bus.in_wb = 0;
    bus.in_warp_num = 0;
    bus.in_cache_req_ready = 1;
    bus.in_cache_rsp_valid = 0;
    bus.in_cache_rsp_data = 0;
    repeat (2) @(negedge clk);
    #1;
    check("reset freeze", bus.out_freeze, 0);
    check("reset req_valid", bus.out_cache_req_valid, 0);
    check("reset mem_valid", bus.out_mem_valid, 0);
    check("reset out_valid", bus.out_valid, 0);
    check("reset result", bus.out_mem_result, 0);
    nop();
    bus.in_cache_req_ready = 0;
    reset_n = 1;
    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      for (int t = 0; t < 4; t++) x[t] = v[i].valid[t] ? v[i].res : 32'h0;
      run_op($sformatf("vec%0d", i), v[i].rd, v[i].wr, v[i].valid, {4{v[i].addr}}, {4{v[i].data}},
             {4{v[i].rsp}}, x, {4{v[i].be}}, {4{v[i].wd}}, 0);
    end
    run_op("sw 1011", 3'd7, 3'd2, 4'b1011, {32'h10C, 32'h108, 32'h104, 32'h100},
           {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, '0, '0,
           {4{4'hF}}, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 0);
    run_op("sb backpressure", 3'd7, 3'd0, 4'b0011, {32'h0, 32'h0, 32'h403, 32'h402},
           {32'h0, 32'h0, 32'hCD, 32'hAB}, '0, '0, {4'h0, 4'h0, 4'b1000, 4'b0100},
           {32'h0, 32'h0, 32'hCDCD_CDCD, 32'hABAB_ABAB}, 3);
    run_op("lw empty mask", 3'd2, 3'd7, 4'b0000, {4{32'h700}}, '0, '0, '0, '0, '0, 0);
    run_op("lh two threads", 3'd1, 3'd7, 4'b0110, {32'h0, 32'h506, 32'h500, 32'h0}, '0,
           {32'h0, 32'h7FFF_0000, 32'h1234_8765, 32'h0}, {32'h0, 32'h0000_7FFF, 32'hFFFF_8765, 32'h0},
           '0, '0, 0);
    bus.in_mem_read = 3'd2;
    bus.in_valid = 4'b0001;
    bus.in_alu_result = {4{32'h600}};
    @(negedge clk);
    #1;
    check("req before reset", bus.out_cache_req_valid, 1);
    reset_n = 0;
    #1;
    check("req drops on reset", bus.out_cache_req_valid, 0);
    check("freeze drops on reset", bus.out_freeze, 0);
    @(negedge clk);
    reset_n = 1;
    bus.in_cache_req_ready = 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("wait state freeze", bus.out_freeze, 1);
    check("wait state req", bus.out_cache_req_valid, 0);
    reset_n = 0;
    #1;
    check("freeze drops in wait", bus.out_freeze, 0);
    @(negedge clk);
    reset_n = 1;
    nop();
    bus.in_cache_req_ready = 0;
    bus.in_cache_rsp_valid = 1;
    bus.in_cache_rsp_data = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.in_cache_rsp_valid = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("late rsp no mem_valid", bus.out_mem_valid, 0);
      check("late rsp no req", bus.out_cache_req_valid, 0);
      @(negedge clk);
    end
    check("late rsp result", bus.out_mem_result, 0);
    run_op("lw after reset", 3'd2, 3'd7, 4'b1000, {4{32'h800}}, '0, {4{32'h0BAD_F00D}},
           {32'h0BAD_F00D, 32'h0, 32'h0, 32'h0}, '0, '0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
